user_input_conditioner: RTL and testbench

- Parametrised front-end for all operator inputs: slide switches and active-low push-buttons.
- Synchronises and debounces every raw input, then derives the algorithm selection index and switch-error flags.
- Produces per-button press, release and auto-repeat pulses.
- Sits between the board pins and the main controller FSM and seven-segment driver, replacing the ad-hoc switch synchroniser and edge detectors.

---
 rtl/user_input_conditioner_pkg.sv | 37 +++
 rtl/user_input_conditioner_if.sv | 33 +++
 rtl/user_input_conditioner_debounce.sv | 63 ++++++
 rtl/user_input_conditioner.sv | 179 +++++++++++++++++
 tb/tb_user_input_conditioner.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/user_input_conditioner_pkg.sv
// Shared types, default timing constants and width helpers for the
// operator input conditioner.
package input_cond_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  localparam int unsigned DEF_N_SW         = 4;
  localparam int unsigned DEF_N_KEY        = 3;
  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_SW_DEBOUNCE  = 1000000;
  localparam int unsigned DEF_KEY_DEBOUNCE = 500000;
  localparam int unsigned DEF_REPEAT_DELAY = 25000000;
  localparam int unsigned DEF_REPEAT_RATE  = 5000000;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned     bits;
    longint unsigned span;
    bits = 0;
    span = 1;
    while (span < 64'(value)) begin
      span = span << 1;
      bits++;
    end
    return bits;
  endfunction

  function automatic int unsigned sel_width(input int unsigned n_sw);
    int unsigned w;
    w = clog2(n_sw);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/user_input_conditioner_if.sv
// Pin-side raw inputs and conditioned outputs of the input conditioner.
interface user_input_conditioner_if #(
  parameter int unsigned N_SW  = 4,
  parameter int unsigned N_KEY = 3,
  parameter int unsigned SEL_W = input_cond_pkg::sel_width(N_SW)
) ();

  logic [N_SW-1:0]  sw_raw;
  logic [N_KEY-1:0] key_n_raw;
  logic [N_SW-1:0]  sw_stable;
  logic [SEL_W-1:0] sel_index;
  logic             sel_valid;
  logic             err_multi;
  logic             err_none;
  logic             sel_change;
  logic [N_KEY-1:0] key_level;
  logic [N_KEY-1:0] key_press;
  logic [N_KEY-1:0] key_release;
  logic [N_KEY-1:0] key_repeat;

  modport master (
    output sw_raw, key_n_raw,
    input  sw_stable, sel_index, sel_valid, err_multi, err_none, sel_change,
    input  key_level, key_press, key_release, key_repeat
  );

  modport slave (
    input  sw_raw, key_n_raw,
    output sw_stable, sel_index, sel_valid, err_multi, err_none, sel_change,
    output key_level, key_press, key_release, key_repeat
  );

endinterface

// File: rtl/user_input_conditioner_debounce.sv
// One input channel: synchroniser chain, stability counter, debounced level
// and registered rise/fall pulses.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 1000000,
  parameter logic        RESET_VAL   = 1'b0,
  parameter logic        INVERT      = 1'b0
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int unsigned          CNT_W    = clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic                 STABLE_RST = RESET_VAL ^ INVERT;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt_q;
  logic                   stable_d;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign synced = sync_q[SYNC_STAGES-1] ^ INVERT;

  // Any cycle where synced matches stable restarts the count, so a glitch
  // back to the old level costs the full debounce window again.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      stable <= STABLE_RST;
    end else if (synced == stable) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q  <= '0;
      stable <= synced;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      stable_d <= STABLE_RST;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      stable_d <= stable;
      rise     <= stable & ~stable_d;
      fall     <= ~stable & stable_d;
    end
  end

endmodule

// File: rtl/user_input_conditioner.sv
// Operator input front-end: debounced switches with algorithm selection and
// error flags, debounced buttons with press/release/auto-repeat pulses.
module user_input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned      N_SW         = DEF_N_SW,
  parameter int unsigned      N_KEY        = DEF_N_KEY,
  parameter int unsigned      SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned      SW_DEBOUNCE  = DEF_SW_DEBOUNCE,
  parameter int unsigned      KEY_DEBOUNCE = DEF_KEY_DEBOUNCE,
  parameter int unsigned      REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned      REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter logic [N_KEY-1:0] REPEAT_MASK  = '0
) (
  input logic                    CLOCK_50,
  input logic                    reset,
  user_input_conditioner_if.slave io
);

  localparam int unsigned SEL_W          = sel_width(N_SW);
  localparam logic [31:0] RPT_DELAY_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RPT_RATE_LAST  = 32'(REPEAT_RATE - 1);

  logic [N_SW-1:0]  sw_stable;
  logic [N_SW-1:0]  sw_rise_unused;
  logic [N_SW-1:0]  sw_fall_unused;
  logic [N_KEY-1:0] key_level;
  logic [N_KEY-1:0] key_press;
  logic [N_KEY-1:0] key_release;
  logic [N_KEY-1:0] key_repeat;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (SW_DEBOUNCE),
      .RESET_VAL  (1'b0),
      .INVERT     (1'b0)
    ) u_db (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .raw     (io.sw_raw[i]),
      .stable  (sw_stable[i]),
      .rise    (sw_rise_unused[i]),
      .fall    (sw_fall_unused[i])
    );
  end

  for (genvar k = 0; k < N_KEY; k++) begin : g_key
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (KEY_DEBOUNCE),
      .RESET_VAL  (1'b1),
      .INVERT     (1'b1)
    ) u_db (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .raw     (io.key_n_raw[k]),
      .stable  (key_level[k]),
      .rise    (key_press[k]),
      .fall    (key_release[k])
    );
  end

  // Selection: lowest set switch wins; only 0 / 1 / many matters for flags.
  logic [SEL_W-1:0] sel_index_c, sel_index_q;
  logic             found_c, multi_c;
  logic             sel_valid_q, err_multi_q, err_none_q;
  logic [SEL_W:0]   sel_prev_q;
  logic             sel_change_q;

  always_comb begin
    sel_index_c = '0;
    found_c     = 1'b0;
    multi_c     = 1'b0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      if (sw_stable[i]) begin
        if (found_c) multi_c = 1'b1;
        else         sel_index_c = SEL_W'(i);
        found_c = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sel_index_q  <= '0;
      sel_valid_q  <= 1'b0;
      err_multi_q  <= 1'b0;
      err_none_q   <= 1'b1;
      sel_prev_q   <= '0;
      sel_change_q <= 1'b0;
    end else begin
      sel_index_q  <= sel_index_c;
      sel_valid_q  <= found_c & ~multi_c;
      err_multi_q  <= multi_c;
      err_none_q   <= ~found_c;
      sel_prev_q   <= {sel_valid_q, sel_index_q};
      sel_change_q <= ({sel_valid_q, sel_index_q} != sel_prev_q);
    end
  end

  // Repeat pulses are decoded combinationally from the counter so the first
  // one lands exactly REPEAT_DELAY cycles after the press pulse.
  for (genvar k = 0; k < N_KEY; k++) begin : g_rpt
    if (REPEAT_MASK[k]) begin : g_on
      rpt_state_t  state_q, state_d;
      logic [31:0] cnt_q, cnt_d;
      logic        rpt;

      always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!key_level[k]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          unique case (state_q)
            IDLE: begin
              if (key_press[k]) begin
                state_d = DELAY;
                cnt_d   = '0;
              end
            end
            DELAY: begin
              if (cnt_q == RPT_DELAY_LAST) begin
                state_d = REPEAT;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + 32'd1;
              end
            end
            REPEAT: begin
              if (cnt_q == RPT_RATE_LAST) cnt_d = '0;
              else                        cnt_d = cnt_q + 32'd1;
            end
            default: begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          endcase
        end
      end

      always_comb begin
        rpt = 1'b0;
        if (key_level[k]) begin
          rpt = ((state_q == DELAY)  && (cnt_q == RPT_DELAY_LAST)) ||
                ((state_q == REPEAT) && (cnt_q == RPT_RATE_LAST));
        end
      end

      assign key_repeat[k] = rpt;
    end else begin : g_off
      assign key_repeat[k] = 1'b0;
    end
  end

  assign io.sw_stable   = sw_stable;
  assign io.sel_index   = sel_index_q;
  assign io.sel_valid   = sel_valid_q;
  assign io.err_multi   = err_multi_q;
  assign io.err_none    = err_none_q;
  assign io.sel_change  = sel_change_q;
  assign io.key_level   = key_level;
  assign io.key_press   = key_press;
  assign io.key_release = key_release;
  assign io.key_repeat  = key_repeat;

endmodule

// File: tb/tb_user_input_conditioner.sv
// Scoreboard bench: each scenario queues the cycle at which every pulse or
// level change must appear; the per-cycle monitor consumes them.
module tb_user_input_conditioner;

  localparam int unsigned N_SW  = 4;
  localparam int unsigned N_KEY = 3;

  localparam int unsigned K_PRESS  = 0;
  localparam int unsigned K_REL    = 4;
  localparam int unsigned K_REP    = 8;
  localparam int unsigned K_SELCHG = 12;
  localparam int unsigned K_SWCHG  = 13;
  localparam int unsigned K_VALID  = 14;
  localparam int unsigned K_LVL    = 16;

  typedef struct {
    int unsigned at;
    int unsigned kind;
  } ev_t;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  int unsigned cyc      = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  ev_t         exp_q[$];

  logic [N_SW-1:0]  prev_sw;
  logic [N_KEY-1:0] prev_lvl;
  logic             prev_valid;

  user_input_conditioner_if #(.N_SW(N_SW), .N_KEY(N_KEY)) io ();

  user_input_conditioner #(
    .N_SW        (N_SW),
    .N_KEY       (N_KEY),
    .SYNC_STAGES (2),
    .SW_DEBOUNCE (8),
    .KEY_DEBOUNCE(4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (6),
    .REPEAT_MASK (3'b011)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .io      (io)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic push_ev(input int unsigned at, input int unsigned kind);
    exp_q.push_back('{at: at, kind: kind});
  endtask

  function automatic bit take(input int unsigned at, input int unsigned kind);
    foreach (exp_q[i]) begin
      if (exp_q[i].at == at && exp_q[i].kind == kind) begin
        exp_q.delete(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic sync_prev();
    prev_sw    = io.sw_stable;
    prev_lvl   = io.key_level;
    prev_valid = io.sel_valid;
  endtask

  // Monitor n cycles: flag one-hot check plus every observed event must be queued.
  task automatic observe(input int unsigned n);
    int unsigned seen[$];
    for (int unsigned c = 0; c < n; c++) begin
      @(negedge CLOCK_50);
      n_checks++;
      if ((32'(io.sel_valid) + 32'(io.err_multi) + 32'(io.err_none)) != 32'd1) begin
        n_fail++;
        $display("FAIL flags_onehot cyc=%0d got valid=%b multi=%b none=%b, want exactly one high",
                 cyc, io.sel_valid, io.err_multi, io.err_none);
      end
      seen = {};
      for (int unsigned k = 0; k < N_KEY; k++) begin
        if (io.key_press[k])            seen.push_back(K_PRESS + k);
        if (io.key_release[k])          seen.push_back(K_REL + k);
        if (io.key_repeat[k])           seen.push_back(K_REP + k);
        if (io.key_level[k] !== prev_lvl[k]) seen.push_back(K_LVL + k);
      end
      if (io.sel_change)              seen.push_back(K_SELCHG);
      if (io.sw_stable !== prev_sw)   seen.push_back(K_SWCHG);
      if (io.sel_valid !== prev_valid) seen.push_back(K_VALID);
      foreach (seen[j]) begin
        n_checks++;
        if (!take(cyc, seen[j])) begin
          n_fail++;
          $display("FAIL event_kind_%0d cyc=%0d got event, expected none this cycle", seen[j], cyc);
        end
      end
      sync_prev();
    end
    for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
      if (exp_q[i].at <= cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_event_kind_%0d got none, expected at cyc=%0d", exp_q[i].kind, exp_q[i].at);
        exp_q.delete(i);
      end
    end
  endtask

  task automatic test_reset();
    io.sw_raw    = '0;
    io.key_n_raw = '1;
    #2 reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    n_checks++;
    if (io.sw_stable !== 4'b0000 || io.key_level !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_levels got sw=%b lvl=%b, want 0000 000", io.sw_stable, io.key_level);
    end
    n_checks++;
    if ({io.sel_index, io.sel_valid, io.err_multi, io.err_none} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_sel got idx=%0d v=%b m=%b n=%b, want 0 0 0 1",
               io.sel_index, io.sel_valid, io.err_multi, io.err_none);
    end
    n_checks++;
    if ({io.key_press, io.key_release, io.key_repeat, io.sel_change} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_pulses got %b %b %b %b, want all 0",
               io.key_press, io.key_release, io.key_repeat, io.sel_change);
    end
    sync_prev();
    @(posedge CLOCK_50); #1 reset = 1'b0;
    observe(6);
  endtask

  task automatic test_switch_clean();
    int unsigned t;
    @(posedge CLOCK_50); #1 io.sw_raw = 4'b0100; t = cyc;
    push_ev(t + 10, K_SWCHG);
    push_ev(t + 11, K_VALID);
    push_ev(t + 12, K_SELCHG);
    observe(11);
    n_checks++;
    if (io.sw_stable !== 4'b0100 || io.sel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_stable got sw=%b valid=%b, want 0100 0", io.sw_stable, io.sel_valid);
    end
    observe(1);
    n_checks++;
    if (io.sel_index !== 2'd2 || io.sel_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_sel got idx=%0d valid=%b, want 2 1", io.sel_index, io.sel_valid);
    end
    observe(6);
  endtask

  task automatic test_bounce();
    int unsigned t4;
    @(posedge CLOCK_50); #1 io.key_n_raw[0] = 1'b0;
    observe(3);
    @(posedge CLOCK_50); #1 io.key_n_raw[0] = 1'b1;
    observe(1);
    @(posedge CLOCK_50); #1 io.key_n_raw[0] = 1'b0; t4 = cyc;
    push_ev(t4 + 6, K_LVL + 0);
    push_ev(t4 + 7, K_PRESS + 0);
    push_ev(t4 + 16, K_LVL + 0);
    push_ev(t4 + 17, K_REL + 0);
    observe(10);
    @(posedge CLOCK_50); #1 io.key_n_raw[0] = 1'b1;
    observe(14);
  endtask

  task automatic hold_key(input int unsigned k, input bit rpt);
    int unsigned t;
    @(posedge CLOCK_50); #1 io.key_n_raw[k] = 1'b0; t = cyc;
    push_ev(t + 6, K_LVL + k);
    push_ev(t + 7, K_PRESS + k);
    if (rpt) begin
      for (int unsigned c = t + 27; c < t + 62; c += 6) push_ev(c, K_REP + k);
    end
    push_ev(t + 62, K_LVL + k);
    push_ev(t + 63, K_REL + k);
    observe(56);
    @(posedge CLOCK_50); #1 io.key_n_raw[k] = 1'b1;
    observe(12);
  endtask

  task automatic test_auto_repeat();
    hold_key(1, 1'b1);
  endtask

  task automatic test_no_repeat_masked();
    hold_key(2, 1'b0);
  endtask

  task automatic test_switch_errors();
    int unsigned t;
    @(posedge CLOCK_50); #1 io.sw_raw = 4'b0000; t = cyc;
    push_ev(t + 10, K_SWCHG); push_ev(t + 11, K_VALID); push_ev(t + 12, K_SELCHG);
    observe(14);
    n_checks++;
    if (io.err_none !== 1'b1 || io.sel_index !== 2'd0) begin
      n_fail++;
      $display("FAIL err_none got none=%b idx=%0d, want 1 0", io.err_none, io.sel_index);
    end
    @(posedge CLOCK_50); #1 io.sw_raw = 4'b1010; t = cyc;
    push_ev(t + 10, K_SWCHG); push_ev(t + 12, K_SELCHG);
    observe(14);
    n_checks++;
    if (io.err_multi !== 1'b1 || io.sel_index !== 2'd1 || io.sel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_multi got multi=%b idx=%0d valid=%b, want 1 1 0",
               io.err_multi, io.sel_index, io.sel_valid);
    end
    @(posedge CLOCK_50); #1 io.sw_raw = 4'b1000; t = cyc;
    push_ev(t + 10, K_SWCHG); push_ev(t + 11, K_VALID); push_ev(t + 12, K_SELCHG);
    observe(14);
    n_checks++;
    if (io.sel_valid !== 1'b1 || io.sel_index !== 2'd3) begin
      n_fail++;
      $display("FAIL sel_top got valid=%b idx=%0d, want 1 3", io.sel_valid, io.sel_index);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int unsigned t, r;
    @(posedge CLOCK_50); #1 io.key_n_raw[1] = 1'b0; t = cyc;
    push_ev(t + 6, K_LVL + 1);
    push_ev(t + 7, K_PRESS + 1);
    push_ev(t + 27, K_REP + 1);
    push_ev(t + 33, K_REP + 1);
    observe(35);
    @(posedge CLOCK_50); #2 reset = 1'b1;
    #1;
    n_checks++;
    if (io.key_level !== 3'b000 || io.key_repeat !== 3'b000 || io.key_press !== 3'b000 ||
        io.sw_stable !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset got lvl=%b rep=%b prs=%b sw=%b, want all 0",
               io.key_level, io.key_repeat, io.key_press, io.sw_stable);
    end
    n_checks++;
    if ({io.sel_index, io.sel_valid, io.err_multi, io.err_none} !== 5'b00001) begin
      n_fail++;
      $display("FAIL async_reset_sel got idx=%0d v=%b m=%b n=%b, want 0 0 0 1",
               io.sel_index, io.sel_valid, io.err_multi, io.err_none);
    end
    sync_prev();
    observe(3);
    @(posedge CLOCK_50); #1 reset = 1'b0; r = cyc;
    // Button still held and switch 3 still on: both re-debounce from scratch.
    push_ev(r + 6, K_LVL + 1);
    push_ev(r + 7, K_PRESS + 1);
    push_ev(r + 10, K_SWCHG);
    push_ev(r + 11, K_VALID);
    push_ev(r + 12, K_SELCHG);
    for (int unsigned c = r + 27; c < r + 46; c += 6) push_ev(c, K_REP + 1);
    push_ev(r + 46, K_LVL + 1);
    push_ev(r + 47, K_REL + 1);
    observe(40);
    @(posedge CLOCK_50); #1 io.key_n_raw[1] = 1'b1;
    observe(12);
  endtask

  initial begin
    test_reset();
    test_switch_clean();
    test_bounce();
    test_auto_repeat();
    test_no_repeat_masked();
    test_switch_errors();
    test_reset_mid_repeat();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending events, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
